imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: turns a little-endian byte stream (16-bit word count, then words)
// into one-per-word instruction-memory writes, holding the CPU until loaded.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int WCW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERR
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [15:0]     len_reg;
  logic [WCW-1:0]  word_cnt_reg;
  logic [1:0]      byte_cnt_reg;
  logic [23:0]     asm_reg;
  logic            wr_en_reg;
  logic [31:0]     wr_addr_reg;
  logic [31:0]     wr_data_reg;

  logic            accept;
  logic            last_word;
  logic [15:0]     len_full;

  assign in_ready  = (state_reg == LEN_LO) || (state_reg == LEN_HI) || (state_reg == DATA);
  assign accept    = in_valid && in_ready;
  assign len_full  = {in_data, len_reg[7:0]};
  assign last_word = ((32'(word_cnt_reg) + 32'd1) == 32'(len_reg));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LEN_LO;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      LEN_LO: begin
        if (accept) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          if (len_full == 16'd0) begin
            state_next = DONE;
          end else if (32'(len_full) > MAX_WORDS) begin
            state_next = ERR;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        // Leave on the same edge that launches the final word's write.
        if (accept && (byte_cnt_reg == 2'd3) && last_word) state_next = DONE;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ERR: begin
        err = 1'b1;
      end
      default: begin
        state_next = LEN_LO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg      <= '0;
      word_cnt_reg <= '0;
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= BASE_ADDR;
      wr_data_reg  <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      if (accept) begin
        case (state_reg)
          LEN_LO: len_reg[7:0]  <= in_data;
          LEN_HI: len_reg[15:8] <= in_data;
          DATA: begin
            case (byte_cnt_reg)
              2'd0: asm_reg[7:0]   <= in_data;
              2'd1: asm_reg[15:8]  <= in_data;
              2'd2: asm_reg[23:16] <= in_data;
              default: begin
                // Fourth byte completes the word; assembly restarts with no bubble.
                wr_en_reg    <= 1'b1;
                wr_data_reg  <= {in_data, asm_reg};
                wr_addr_reg  <= BASE_ADDR + (32'(word_cnt_reg) << 2);
                word_cnt_reg <= word_cnt_reg + WCW'(1);
                asm_reg      <= '0;
              end
            endcase
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

endmodule
